// File: rtl/nonce_search_ctrl.sv
// Nonce-search controller: walks a nonce range through an external hash core
// and stops on the first hash whose leading bytes fall below the target.
module nonce_search_ctrl #(
   parameter int unsigned HEADER_BYTES = 12,
   parameter int unsigned NONCE_BYTES  = 4,
   parameter int unsigned HASH_BYTES   = 3,
   parameter int unsigned TARGET_BYTES = 1
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     start_i,
   input  logic                                     abort_i,
   input  logic [8*HEADER_BYTES-1:0]                header_i,
   input  logic [8*NONCE_BYTES-1:0]                 nonce_start_i,
   input  logic [8*NONCE_BYTES-1:0]                 nonce_limit_i,
   input  logic [8*TARGET_BYTES-1:0]                target_i,
   output logic [8*(HEADER_BYTES+NONCE_BYTES)-1:0]  block_out_o,
   output logic                                     hash_start_o,
   input  logic                                     hash_done_i,
   input  logic [8*HASH_BYTES-1:0]                  hash_in_i,
   output logic                                     busy_o,
   output logic                                     found_o,
   output logic                                     exhausted_o,
   output logic [8*NONCE_BYTES-1:0]                 nonce_out_o,
   output logic [8*HASH_BYTES-1:0]                  hash_out_o,
   output logic [8*NONCE_BYTES:0]                   attempts_o
);

   localparam int unsigned HW = 8 * HEADER_BYTES;
   localparam int unsigned NW = 8 * NONCE_BYTES;
   localparam int unsigned SW = 8 * HASH_BYTES;
   localparam int unsigned TW = 8 * TARGET_BYTES;
   localparam int unsigned AW = NW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [HW-1:0]   header_q, header_d;
   logic [TW-1:0]   target_q, target_d;
   logic [NW-1:0]   nonce_q, nonce_d;
   logic [NW-1:0]   limit_q, limit_d;
   logic [SW-1:0]   hash_q, hash_d;
   logic [AW-1:0]   attempts_q, attempts_d;
   logic            found_q, found_d;
   logic            exhausted_q, exhausted_d;
   logic            hash_start_q, hash_start_d;
   logic            busy_q, busy_d;
   logic            pass_c;

   // Only the most significant TARGET_BYTES of the hash take part in the compare
   assign pass_c = (hash_q[SW-1 -: TW] < target_q);

   always_comb begin
      state_d     = state_q;
      header_d    = header_q;
      target_d    = target_q;
      nonce_d     = nonce_q;
      limit_d     = limit_q;
      hash_d      = hash_q;
      attempts_d  = attempts_q;
      found_d     = found_q;
      exhausted_d = exhausted_q;

      if (abort_i) begin
         // abort wins over start and hash_done; result registers are kept
         state_d     = S_IDLE;
         found_d     = 1'b0;
         exhausted_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  header_d    = header_i;
                  target_d    = target_i;
                  nonce_d     = nonce_start_i;
                  limit_d     = nonce_limit_i;
                  hash_d      = '0;
                  attempts_d  = '0;
                  found_d     = 1'b0;
                  exhausted_d = 1'b0;
                  state_d     = S_ISSUE;
               end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
               if (hash_done_i) begin
                  hash_d     = hash_in_i;
                  attempts_d = attempts_q + AW'(1);
                  state_d    = S_CHECK;
               end
            end
            S_CHECK: begin
               if (pass_c) begin
                  found_d = 1'b1;
                  state_d = S_DONE;
               end else if (nonce_q == limit_q) begin
                  exhausted_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  nonce_d = nonce_q + NW'(1);
                  state_d = S_ISSUE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // strobes decoded from the next state so they appear with the state itself
      hash_start_d = (state_d == S_ISSUE);
      busy_d       = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CHECK);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         header_q     <= '0;
         target_q     <= '0;
         nonce_q      <= '0;
         limit_q      <= '0;
         hash_q       <= '0;
         attempts_q   <= '0;
         found_q      <= 1'b0;
         exhausted_q  <= 1'b0;
         hash_start_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         header_q     <= header_d;
         target_q     <= target_d;
         nonce_q      <= nonce_d;
         limit_q      <= limit_d;
         hash_q       <= hash_d;
         attempts_q   <= attempts_d;
         found_q      <= found_d;
         exhausted_q  <= exhausted_d;
         hash_start_q <= hash_start_d;
         busy_q       <= busy_d;
      end
   end

   assign block_out_o  = {header_q, nonce_q};
   assign hash_start_o = hash_start_q;
   assign busy_o       = busy_q;
   assign found_o      = found_q;
   assign exhausted_o  = exhausted_q;
   assign nonce_out_o  = nonce_q;
   assign hash_out_o   = hash_q;
   assign attempts_o   = attempts_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Scoreboard bench for nonce_search_ctrl: a hash-core model answers hash_start,
// expected blocks and search results are queued at stimulus time and checked by monitors.
module tb_nonce_search_ctrl;

   logic clk;
   logic rst_n;

   // default-parameter instance (12/4/3/1)
   logic         a_start, a_abort, a_hs, a_hd, a_busy, a_found, a_exh;
   logic [95:0]  a_header;
   logic [31:0]  a_ns, a_nl, a_nonce;
   logic [7:0]   a_target;
   logic [127:0] a_block;
   logic [23:0]  a_hin, a_hash;
   logic [32:0]  a_att;

   // parametrised instance (8/2/4/2)
   logic         b_start, b_abort, b_hs, b_hd, b_busy, b_found, b_exh;
   logic [63:0]  b_header;
   logic [15:0]  b_ns, b_nl, b_nonce, b_target;
   logic [79:0]  b_block;
   logic [31:0]  b_hin, b_hash;
   logic [16:0]  b_att;

   // one-byte-nonce instance for the full-range wrap (2/1/1/1)
   logic         c_start, c_abort, c_hs, c_hd, c_busy, c_found, c_exh;
   logic [15:0]  c_header;
   logic [7:0]   c_ns, c_nl, c_nonce, c_target, c_hin, c_hash;
   logic [23:0]  c_block;
   logic [8:0]   c_att;

   nonce_search_ctrl #(.HEADER_BYTES(12), .NONCE_BYTES(4), .HASH_BYTES(3), .TARGET_BYTES(1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .abort_i(a_abort), .header_i(a_header),
      .nonce_start_i(a_ns), .nonce_limit_i(a_nl), .target_i(a_target), .block_out_o(a_block),
      .hash_start_o(a_hs), .hash_done_i(a_hd), .hash_in_i(a_hin), .busy_o(a_busy),
      .found_o(a_found), .exhausted_o(a_exh), .nonce_out_o(a_nonce), .hash_out_o(a_hash),
      .attempts_o(a_att));

   nonce_search_ctrl #(.HEADER_BYTES(8), .NONCE_BYTES(2), .HASH_BYTES(4), .TARGET_BYTES(2)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .abort_i(b_abort), .header_i(b_header),
      .nonce_start_i(b_ns), .nonce_limit_i(b_nl), .target_i(b_target), .block_out_o(b_block),
      .hash_start_o(b_hs), .hash_done_i(b_hd), .hash_in_i(b_hin), .busy_o(b_busy),
      .found_o(b_found), .exhausted_o(b_exh), .nonce_out_o(b_nonce), .hash_out_o(b_hash),
      .attempts_o(b_att));

   nonce_search_ctrl #(.HEADER_BYTES(2), .NONCE_BYTES(1), .HASH_BYTES(1), .TARGET_BYTES(1)) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .start_i(c_start), .abort_i(c_abort), .header_i(c_header),
      .nonce_start_i(c_ns), .nonce_limit_i(c_nl), .target_i(c_target), .block_out_o(c_block),
      .hash_start_o(c_hs), .hash_done_i(c_hd), .hash_in_i(c_hin), .busy_o(c_busy),
      .found_o(c_found), .exhausted_o(c_exh), .nonce_out_o(c_nonce), .hash_out_o(c_hash),
      .attempts_o(c_att));

   typedef struct packed {
      logic        found;
      logic        exh;
      logic [31:0] nonce;
      logic [32:0] att;
      logic [23:0] hash;
   } res_t;

   res_t         exp_res[$];
   logic [127:0] exp_blk[$];
   logic [23:0]  script[$];
   logic [31:0]  seed;
   int           core_idx;
   int           core_fixed_lat;
   int           total = 0;
   int           bad   = 0;

   logic [31:0]  b_script [3] = '{32'h0100_0000, 32'h1234_5678, 32'h00FF_1234};
   int           b_idx;
   int           c_cnt;
   logic [7:0]   c_last;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] mix(input logic [31:0] n, input logic [31:0] s);
      logic [31:0] x;
      x = (n ^ s) * 32'h9E37_79B1;
      x = x ^ (x >> 15);
      return x[31:8];
   endfunction

   // hash the core model returns for the idx-th attempt of a search on nonce n
   function automatic logic [23:0] core_hash(input int idx, input logic [31:0] n);
      if (idx < script.size()) return script[idx];
      return mix(n, seed);
   endfunction

   // reference: enumerate the (possibly wrapping) range and stop at the first passing hash
   function automatic void predict(input logic [95:0] hdr, input logic [31:0] ns,
                                   input logic [31:0] nl, input logic [7:0] tgt);
      res_t        r;
      logic [32:0] cnt;
      logic [31:0] n;
      logic [23:0] h;
      cnt     = {1'b0, nl - ns} + 33'd1;
      r.found = 1'b0;
      r.exh   = 1'b0;
      r.nonce = ns;
      r.att   = '0;
      r.hash  = '0;
      for (longint i = 0; i < longint'(cnt); i++) begin
         n = ns + 32'(i);
         h = core_hash(int'(i), n);
         exp_blk.push_back({hdr, n});
         r.nonce = n;
         r.att   = 33'(i + 1);
         r.hash  = h;
         if (h[23:16] < tgt) begin
            r.found = 1'b1;
            break;
         end
      end
      r.exh = !r.found;
      exp_res.push_back(r);
   endfunction

   // hash core model for instance a: checks each issued block, answers after 1..4 cycles
   initial begin
      logic [127:0] eb;
      logic [23:0]  h;
      int           lat;
      a_hd  = 1'b0;
      a_hin = '0;
      forever begin
         @(posedge clk); #1;
         if (a_hs) begin
            if (exp_blk.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_hash_start actual=%0h required=none", a_block);
            end else begin
               eb = exp_blk.pop_front();
               check("block_out", a_block, eb);
            end
            h = core_hash(core_idx, a_block[31:0]);
            core_idx++;
            lat = (core_fixed_lat > 0) ? core_fixed_lat : int'($urandom_range(4, 1));
            repeat (lat) @(posedge clk);
            #1;
            a_hd  = 1'b1;
            a_hin = h;
            @(posedge clk); #1;
            a_hd = 1'b0;
         end
      end
   end

   // result monitor for instance a: a search ends when busy falls with found or exhausted set
   initial begin
      res_t r;
      logic pb;
      pb = 1'b0;
      forever begin
         @(negedge clk);
         if (pb && !a_busy && (a_found || a_exh)) begin
            if (exp_res.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done actual=%0h required=none", a_nonce);
            end else begin
               r = exp_res.pop_front();
               check("res_found", 128'(a_found), 128'(r.found));
               check("res_exhausted", 128'(a_exh), 128'(r.exh));
               check("res_nonce", 128'(a_nonce), 128'(r.nonce));
               check("res_attempts", 128'(a_att), 128'(r.att));
               check("res_hash", 128'(a_hash), 128'(r.hash));
            end
         end
         pb = a_busy;
      end
   end

   initial begin
      b_hd  = 1'b0;
      b_hin = '0;
      forever begin
         @(posedge clk); #1;
         b_hd = 1'b0;
         if (b_hs) begin
            @(posedge clk); #1;
            b_hin = (b_idx < 3) ? b_script[b_idx] : 32'hFFFF_FFFF;
            b_hd  = 1'b1;
            b_idx++;
         end
      end
   end

   initial begin
      c_hd  = 1'b0;
      c_hin = '0;
      forever begin
         @(posedge clk); #1;
         c_hd = 1'b0;
         if (c_hs) begin
            c_cnt++;
            @(posedge clk); #1;
            c_hin  = 8'($urandom);
            c_last = c_hin;
            c_hd   = 1'b1;
         end
      end
   end

   task automatic run_a(input logic [95:0] hdr, input logic [31:0] ns, input logic [31:0] nl,
                        input logic [7:0] tgt, input bit hold2);
      int cyc;
      core_idx = 0;
      predict(hdr, ns, nl, tgt);
      @(posedge clk); #1;
      a_header = hdr;
      a_ns     = ns;
      a_nl     = nl;
      a_target = tgt;
      a_start  = 1'b1;
      @(posedge clk); #1;
      check("hash_start_latency", 128'(a_hs), 128'd1);
      check("busy_after_start", 128'(a_busy), 128'd1);
      // captured copies must be used from here on, whatever the inputs do
      a_header = {$urandom, $urandom, $urandom};
      a_ns     = $urandom;
      a_nl     = $urandom;
      a_target = 8'($urandom);
      if (hold2) begin
         @(posedge clk); #1;
      end
      a_start = 1'b0;
      cyc = 0;
      while (!(a_found || a_exh) && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 2000) begin
         total++;
         bad++;
         $display("FAIL search_timeout actual=%0d required=done", cyc);
      end
      @(negedge clk);
   endtask

   initial begin
      logic [95:0] hdr;
      logic [63:0] hdr_b;
      logic [31:0] ns;
      int          cyc;

      rst_n   = 1'b0;
      a_start = 1'b0; a_abort = 1'b0; a_header = '0; a_ns = '0; a_nl = '0; a_target = '0;
      b_start = 1'b0; b_abort = 1'b0; b_header = '0; b_ns = '0; b_nl = '0; b_target = '0;
      c_start = 1'b0; c_abort = 1'b0; c_header = '0; c_ns = '0; c_nl = '0; c_target = '0;
      core_idx = 0; core_fixed_lat = 0; seed = 32'h1; b_idx = 0; c_cnt = 0; c_last = '0;

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_start  = 1'($urandom); a_abort = 1'($urandom);
         a_header = {$urandom, $urandom, $urandom};
         a_ns = $urandom; a_nl = $urandom; a_target = 8'($urandom);
         b_start  = 1'($urandom); b_header = {$urandom, $urandom};
         c_start  = 1'($urandom); c_ns = 8'($urandom);
      end
      #1;
      check("rst_block", a_block, 128'd0);
      check("rst_nonce", 128'(a_nonce), 128'd0);
      check("rst_hash", 128'(a_hash), 128'd0);
      check("rst_attempts", 128'(a_att), 128'd0);
      check("rst_flags", 128'({a_hs, a_busy, a_found, a_exh}), 128'd0);
      check("rst_b_block", 128'(b_block), 128'd0);
      check("rst_b_attempts", 128'(b_att), 128'd0);
      check("rst_c_outputs", 128'({c_nonce, c_busy, c_hs}), 128'd0);

      @(negedge clk);
      a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; c_start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_busy", 128'({a_busy, a_hs}), 128'd0);

      // first-hit pass
      hdr = {$urandom, $urandom, $urandom};
      seed = $urandom;
      script = {24'h3F_0000};
      run_a(hdr, 32'h10, 32'h20, 8'h40, 1'b0);
      check("first_hit_block", a_block, {hdr, 32'h0000_0010});
      check("first_hit_attempts", 128'(a_att), 128'd1);

      // abort while in DONE clears the flags but keeps the result
      @(posedge clk); #1;
      a_abort = 1'b1;
      @(posedge clk); #1;
      a_abort = 1'b0;
      check("done_abort_flags", 128'({a_found, a_exh, a_busy}), 128'd0);
      check("done_abort_nonce", 128'(a_nonce), 128'h10);
      check("done_abort_attempts", 128'(a_att), 128'd1);

      // equality with the target must not pass
      script = {24'h40_0000, 24'h40_1234, 24'h39_FFFF};
      run_a({$urandom, $urandom, $urandom}, 32'd5, 32'h20, 8'h40, 1'b0);
      check("boundary_nonce", 128'(a_nonce), 128'd7);
      check("boundary_attempts", 128'(a_att), 128'd3);

      // wrap through 2^32-1 to 0 and exhaust
      script.delete();
      seed = $urandom;
      run_a({$urandom, $urandom, $urandom}, 32'hFFFF_FFFE, 32'h1, 8'h00, 1'b0);
      check("wrap_flags", 128'({a_found, a_exh}), 128'b01);
      check("wrap_attempts", 128'(a_att), 128'd4);
      check("wrap_nonce", 128'(a_nonce), 128'd1);

      // abort during WAIT with the core answering later
      core_fixed_lat = 4;
      core_idx = 0;
      hdr = {$urandom, $urandom, $urandom};
      ns  = $urandom;
      exp_blk.push_back({hdr, ns});
      @(posedge clk); #1;
      a_header = hdr; a_ns = ns; a_nl = ns + 32'd9; a_target = 8'h00; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      check("abort_hs", 128'(a_hs), 128'd1);
      @(posedge clk); #1;
      a_abort = 1'b1;
      @(posedge clk); #1;
      a_abort = 1'b0;
      check("abort_idle", 128'({a_busy, a_hs, a_found, a_exh}), 128'd0);
      repeat (6) @(posedge clk);
      #1;
      check("abort_attempts", 128'(a_att), 128'd0);
      check("abort_hash", 128'(a_hash), 128'd0);
      check("abort_nonce", 128'(a_nonce), 128'(ns));
      check("abort_busy", 128'(a_busy), 128'd0);

      // start together with abort stays idle and captures nothing
      a_ns = ns + 32'd100; a_start = 1'b1; a_abort = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0; a_abort = 1'b0;
      check("start_abort_busy", 128'(a_busy), 128'd0);
      check("start_abort_nonce", 128'(a_nonce), 128'(ns));
      @(posedge clk); #1;
      check("start_abort_hs", 128'(a_hs), 128'd0);

      // reset in the middle of a search; the late hash_done must be ignored
      core_idx = 0;
      hdr = {$urandom, $urandom, $urandom};
      ns  = $urandom;
      exp_blk.push_back({hdr, ns});
      a_header = hdr; a_ns = ns; a_nl = ns + 32'd5; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_state", 128'({a_busy, a_hs}), 128'd0);
      check("midrst_block", a_block, 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("midrst_hash", 128'(a_hash), 128'd0);
      check("midrst_attempts", 128'({a_att, a_busy}), 128'd0);
      core_fixed_lat = 0;

      // randomized searches, some holding start into the busy phase
      for (int t = 0; t < 30; t++) begin
         logic [31:0] rns;
         script.delete();
         seed = $urandom;
         rns  = $urandom;
         run_a({$urandom, $urandom, $urandom}, rns, rns + 32'($urandom_range(12, 0)),
               8'($urandom_range(48, 0)), 1'($urandom));
      end

      // wider hash / two-byte target / two-byte nonce wrapping past 0xFFFF
      hdr_b = {$urandom, $urandom};
      b_idx = 0;
      @(posedge clk); #1;
      b_header = hdr_b; b_ns = 16'hFFFE; b_nl = 16'h0005; b_target = 16'h0100; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      cyc = 0;
      while (!(b_found || b_exh) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b_flags", 128'({b_found, b_exh}), 128'b10);
      check("b_nonce", 128'(b_nonce), 128'd0);
      check("b_attempts", 128'(b_att), 128'd3);
      check("b_hash", 128'(b_hash), 128'h00FF_1234);
      check("b_block", 128'(b_block), 128'({hdr_b, 16'h0000}));
      check("b_hash_starts", 128'(b_idx), 128'd3);

      // full range on a one-byte nonce: 256 attempts needs the extra attempts bit
      c_cnt = 0;
      @(posedge clk); #1;
      c_header = 16'(($urandom)); c_ns = 8'($urandom); c_nl = c_ns - 8'd1; c_target = 8'h00;
      c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0;
      cyc = 0;
      while (!(c_found || c_exh) && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("c_flags", 128'({c_found, c_exh}), 128'b01);
      check("c_attempts", 128'(c_att), 128'h100);
      check("c_nonce", 128'(c_nonce), 128'(c_nl));
      check("c_hash", 128'(c_hash), 128'(c_last));
      check("c_hash_starts", 128'(c_cnt), 128'd256);

      repeat (4) @(posedge clk);
      #1;
      check("pending_results", 128'(exp_res.size()), 128'd0);
      check("pending_blocks", 128'(exp_blk.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
